// File: rtl/jtag_sync_pkg.sv
// Shared constants and helpers for the multi-channel input synchroniser.
package jtag_sync_pkg;

    localparam int unsigned MIN_SYNC_STAGES   = 2;
    localparam int unsigned MIN_FILTER_CYCLES = 1;

    // Counter must hold values up to FILTER_CYCLES-1; sized for FILTER_CYCLES+1 states.
    function automatic int unsigned filter_cnt_width(input int unsigned filter_cycles);
        return $clog2(filter_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_filter_channel.sv
// One synchroniser channel: metastability chain, optional glitch filter
// (MULTI_CHANNEL_SYNCHRONIZER_GLITCH_FILTER_EN) and registered edge strobes.
module sync_filter_channel #(
    parameter int unsigned SYNC_STAGES   = 2,
`ifdef MULTI_CHANNEL_SYNCHRONIZER_GLITCH_FILTER_EN
    parameter int unsigned FILTER_CYCLES = 3,
`endif
    parameter logic        RESET_VAL     = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o,
    output logic edge_next_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;
    logic                   q_q;
    logic                   q_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    assign s      = sync_q[SYNC_STAGES-1];

`ifdef MULTI_CHANNEL_SYNCHRONIZER_GLITCH_FILTER_EN
    import jtag_sync_pkg::*;

    localparam int unsigned      CNT_W    = filter_cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Accept a new level only after it has been stable at S for FILTER_CYCLES cycles.
    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        if (s == q_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            q_d   = s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign q_d = s;
`endif

    always_comb begin
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;
    end

    assign edge_next_c = rise_d | fall_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            q_q    <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q_o    = q_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/multi_channel_synchronizer.sv
// NR_CHANNELS independent synchroniser channels plus a combined edge strobe.
// Glitch filter enabled by MULTI_CHANNEL_SYNCHRONIZER_GLITCH_FILTER_EN.
module multi_channel_synchronizer
    import jtag_sync_pkg::*;
#(
    parameter int unsigned            NR_CHANNELS   = 4,
    parameter int unsigned            SYNC_STAGES   = 2,
    parameter int unsigned            FILTER_CYCLES = 3,
    parameter logic [NR_CHANNELS-1:0] RESET_VALUE   = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NR_CHANNELS-1:0] D,
    output logic [NR_CHANNELS-1:0] Q,
    output logic [NR_CHANNELS-1:0] risingEdge,
    output logic [NR_CHANNELS-1:0] fallingEdge,
    output logic                   anyEdge
);

    logic [NR_CHANNELS-1:0] edge_next;
    logic                   any_q;
    logic                   any_d;

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("multi_channel_synchronizer: SYNC_STAGES must be >= 2");
    end
    if (FILTER_CYCLES < MIN_FILTER_CYCLES) begin : g_bad_filter
        $error("multi_channel_synchronizer: FILTER_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < int'(NR_CHANNELS); i++) begin : g_ch
        sync_filter_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
`ifdef MULTI_CHANNEL_SYNCHRONIZER_GLITCH_FILTER_EN
            .FILTER_CYCLES (FILTER_CYCLES),
`endif
            .RESET_VAL     (RESET_VALUE[i])
        ) u_ch (
            .clock       (clock),
            .reset       (reset),
            .d_i         (D[i]),
            .q_o         (Q[i]),
            .rise_o      (risingEdge[i]),
            .fall_o      (fallingEdge[i]),
            .edge_next_c (edge_next[i])
        );
    end

    // Registered from the channels' next-edge terms so it lines up with the pulses.
    assign any_d = |edge_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            any_q <= 1'b0;
        end else begin
            any_q <= any_d;
        end
    end

    assign anyEdge = any_q;

endmodule

// File: tb/tb_multi_channel_synchronizer.sv
// Directed bench for multi_channel_synchronizer; expectations follow the
// MULTI_CHANNEL_SYNCHRONIZER_GLITCH_FILTER_EN setting of the build.
module tb_multi_channel_synchronizer;

`ifdef MULTI_CHANNEL_SYNCHRONIZER_GLITCH_FILTER_EN
    localparam bit          FILT = 1'b1;
    localparam int unsigned LAT  = 2 + 3;
`else
    localparam bit          FILT = 1'b0;
    localparam int unsigned LAT  = 2 + 1;
`endif
    localparam int unsigned LAT2 = 4 + 1;

    logic       clock;
    logic       reset;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any_edge;
    logic [3:0] d2;
    logic [3:0] q2;
    logic [3:0] rise2;
    logic [3:0] fall2;
    logic       any2;

    int checks = 0;
    int errors = 0;

    multi_channel_synchronizer #(
        .NR_CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(3), .RESET_VALUE(4'h0)
    ) dut (
        .clock(clock), .reset(reset), .D(d), .Q(q),
        .risingEdge(rise), .fallingEdge(fall), .anyEdge(any_edge)
    );

    multi_channel_synchronizer #(
        .NR_CHANNELS(4), .SYNC_STAGES(4), .FILTER_CYCLES(1), .RESET_VALUE(4'h0)
    ) dut2 (
        .clock(clock), .reset(reset), .D(d2), .Q(q2),
        .risingEdge(rise2), .fallingEdge(fall2), .anyEdge(any2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        d     = 4'h0;
        d2    = 4'h0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic settle(input logic [3:0] val);
        d = val;
        for (int i = 0; i < int'(LAT) + 2; i++) tick();
    endtask

    task automatic test_reset();
        logic [3:0] eq, er;
        logic       ea;
        reset = 1'b1;
        d     = 4'hF;
        d2    = 4'h0;
        tick();
        tick();
        checks++;
        if (q !== 4'h0) begin errors++; $display("FAIL reset_q got %h want 0", q); end
        checks++;
        if (rise !== 4'h0 || fall !== 4'h0 || any_edge !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got r=%h f=%h a=%b want 0", rise, fall, any_edge);
        end
        reset = 1'b0;
        for (int k = 1; k <= int'(LAT) + 2; k++) begin
            tick();
            eq = (k >= int'(LAT)) ? 4'hF : 4'h0;
            er = (k == int'(LAT)) ? 4'hF : 4'h0;
            ea = (k == int'(LAT));
            checks++;
            if (q !== eq || rise !== er || fall !== 4'h0 || any_edge !== ea) begin
                errors++;
                $display("FAIL release k=%0d got q=%h r=%h f=%h a=%b want q=%h r=%h f=0 a=%b",
                         k, q, rise, fall, any_edge, eq, er, ea);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] eq, er, ef;
        logic       ea;
        apply_reset();
        d[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 2) d[0] = 1'b0;
            if (FILT) begin
                eq = 4'h0; er = 4'h0; ef = 4'h0;
            end else begin
                eq = (k == 3 || k == 4) ? 4'h1 : 4'h0;
                er = (k == 3) ? 4'h1 : 4'h0;
                ef = (k == 5) ? 4'h1 : 4'h0;
            end
            ea = (er != 4'h0) || (ef != 4'h0);
            checks++;
            if (q !== eq || rise !== er || fall !== ef || any_edge !== ea) begin
                errors++;
                $display("FAIL glitch k=%0d got q=%h r=%h f=%h a=%b want q=%h r=%h f=%h a=%b",
                         k, q, rise, fall, any_edge, eq, er, ef, ea);
            end
        end
    endtask

    task automatic test_single_fall();
        logic [3:0] eq, ef;
        settle(4'hF);
        checks++;
        if (q !== 4'hF) begin errors++; $display("FAIL fall_pre got %h want f", q); end
        d = 4'hB;
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            tick();
            eq = (k >= int'(LAT)) ? 4'hB : 4'hF;
            ef = (k == int'(LAT)) ? 4'h4 : 4'h0;
            checks++;
            if (q !== eq || rise !== 4'h0 || fall !== ef || any_edge !== (k == int'(LAT))) begin
                errors++;
                $display("FAIL fall k=%0d got q=%h r=%h f=%h a=%b want q=%h r=0 f=%h",
                         k, q, rise, fall, any_edge, eq, ef);
            end
        end
    endtask

    task automatic test_opposite();
        logic [3:0] eq, er, ef;
        settle(4'h3);
        checks++;
        if (q !== 4'h3) begin errors++; $display("FAIL opp_pre got %h want 3", q); end
        d = 4'hC;
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            tick();
            eq = (k >= int'(LAT)) ? 4'hC : 4'h3;
            er = (k == int'(LAT)) ? 4'hC : 4'h0;
            ef = (k == int'(LAT)) ? 4'h3 : 4'h0;
            checks++;
            if (q !== eq || rise !== er || fall !== ef || any_edge !== (k == int'(LAT))) begin
                errors++;
                $display("FAIL opposite k=%0d got q=%h r=%h f=%h a=%b want q=%h r=%h f=%h",
                         k, q, rise, fall, any_edge, eq, er, ef);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] eq, er;
        settle(4'hD);
        checks++;
        if (q !== 4'hD) begin errors++; $display("FAIL mid_pre got %h want d", q); end
        d = 4'hF;
        for (int k = 0; k < 4; k++) tick();
        #4;
        reset = 1'b1;
        #1;
        checks++;
        if (q !== 4'h0 || rise !== 4'h0 || fall !== 4'h0 || any_edge !== 1'b0) begin
            errors++;
            $display("FAIL mid_async got q=%h r=%h f=%h a=%b want all 0", q, rise, fall, any_edge);
        end
        tick();
        tick();
        checks++;
        if (q !== 4'h0 || rise !== 4'h0 || fall !== 4'h0 || any_edge !== 1'b0) begin
            errors++;
            $display("FAIL mid_held got q=%h r=%h f=%h a=%b want all 0", q, rise, fall, any_edge);
        end
        reset = 1'b0;
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            tick();
            eq = (k >= int'(LAT)) ? 4'hF : 4'h0;
            er = (k == int'(LAT)) ? 4'hF : 4'h0;
            checks++;
            if (q !== eq || rise !== er || fall !== 4'h0 || any_edge !== (k == int'(LAT))) begin
                errors++;
                $display("FAIL mid_release k=%0d got q=%h r=%h f=%h a=%b want q=%h r=%h",
                         k, q, rise, fall, any_edge, eq, er);
            end
        end
    endtask

    task automatic test_toggle();
        logic       hist [0:63];
        logic       eq1, prev1;
        logic [3:0] eq, er, ef;
        apply_reset();
        d[1]    = 1'b1;
        hist[0] = 1'b1;
        prev1   = 1'b0;
        for (int k = 1; k <= 20 + int'(LAT) + 2; k++) begin
            tick();
            if (FILT) eq1 = 1'b0;
            else      eq1 = (k >= int'(LAT)) ? hist[k - int'(LAT)] : 1'b0;
            d[1]    = (k < 20) ? ~d[1] : 1'b0;
            hist[k] = d[1];
            eq = {2'b00, eq1, 1'b0};
            er = {2'b00, eq1 & ~prev1, 1'b0};
            ef = {2'b00, ~eq1 & prev1, 1'b0};
            prev1 = eq1;
            checks++;
            if (q !== eq || rise !== er || fall !== ef || any_edge !== (eq1 != prev1 || er != 4'h0 || ef != 4'h0)) begin
                errors++;
                $display("FAIL toggle k=%0d got q=%h r=%h f=%h a=%b want q=%h r=%h f=%h",
                         k, q, rise, fall, any_edge, eq, er, ef);
            end
        end
    endtask

    task automatic test_variant();
        logic [3:0] eq, er;
        d2 = 4'h8;
        for (int k = 1; k <= int'(LAT2) + 1; k++) begin
            tick();
            eq = (k >= int'(LAT2)) ? 4'h8 : 4'h0;
            er = (k == int'(LAT2)) ? 4'h8 : 4'h0;
            checks++;
            if (q2 !== eq || rise2 !== er || fall2 !== 4'h0 || any2 !== (k == int'(LAT2))) begin
                errors++;
                $display("FAIL variant k=%0d got q=%h r=%h f=%h a=%b want q=%h r=%h",
                         k, q2, rise2, fall2, any2, eq, er);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        d     = 4'h0;
        d2    = 4'h0;
        test_reset();
        test_glitch();
        test_single_fall();
        test_opposite();
        test_reset_mid();
        test_toggle();
        test_variant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_channel_synchronizer.md
Name: multi_channel_synchronizer

Overview:
Parametrised synchroniser for NR_CHANNELS asynchronous single-bit inputs, such as JTAG TCK/TMS/TDI/TRST pins, sampled into the system clock domain. Each channel has a configurable-depth flip-flop chain, an optional glitch filter and registered rising/falling edge pulses. It sits between the JTAG pads and the TAP controller/interface logic, so downstream logic sees clean levels and one-cycle edge strobes.

Parameters:
NR_CHANNELS, 4, number of independent 1-bit channels (>=1)
SYNC_STAGES, 2, flip-flops in each metastability chain (>=2)
FILTER_CYCLES, 3, consecutive stable cycles needed before a level change is accepted (>=1; used only with the filter compiled in)
RESET_VALUE, 0, NR_CHANNELS-bit reset value of the chains and of Q

Ports:
clock  input  1  system clock; all state is on the rising edge
reset  input  1  asynchronous, active-high reset
D  input  NR_CHANNELS  asynchronous inputs
Q  output  NR_CHANNELS  synchronised (and filtered) levels
risingEdge  output  NR_CHANNELS  one-cycle pulse per channel when Q goes 0->1
fallingEdge  output  NR_CHANNELS  one-cycle pulse per channel when Q goes 1->0
anyEdge  output  1  OR of all risingEdge and fallingEdge bits, registered

Behaviour:
- Reset (async, active-high): all chain stages <= RESET_VALUE; Q <= RESET_VALUE; filter counters <= 0; risingEdge, fallingEdge and anyEdge <= 0. Outputs change immediately on assertion, not at a clock edge.
- No edge pulse is generated by reset assertion or release. If D differs from RESET_VALUE after release, a normal edge follows after the pipeline latency.
- Chain: sync[0] <= D; sync[k] <= sync[k-1]. Call the last stage S.
- Filter, per channel. The counter is $clog2(FILTER_CYCLES+1) bits wide.
  - If S == Q: cnt <= 0.
  - Else if cnt == FILTER_CYCLES-1: Q <= S and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any return of S to Q before acceptance clears cnt, so pulses shorter than FILTER_CYCLES cycles at S are suppressed.
- Latency from a clean D change (setup met) to Q: SYNC_STAGES + FILTER_CYCLES clock edges. With FILTER_CYCLES=1 the latency is SYNC_STAGES+1.
- Edges: risingEdge[i] and fallingEdge[i] are registered on the same clock edge that updates Q[i], computed from the next and current Q. Each is high for exactly one cycle, coinciding with the first cycle of the new Q value.
- anyEdge is registered on that same edge, so it is aligned with the pulses.
- Channels are fully independent. Simultaneous opposite edges on different channels are reported in the same cycle.
- A D toggle every cycle never produces Q activity when FILTER_CYCLES >= 2.
- Reset mid-filter discards the pending count; no pulse is produced.

Optional Feature:
Macro MULTI_CHANNEL_SYNCHRONIZER_GLITCH_FILTER_EN.
- Defined: filter as described above; FILTER_CYCLES is honoured.
- Undefined: no counters. Q <= S every cycle, latency is SYNC_STAGES+1, edges are derived identically, and FILTER_CYCLES is ignored. Any pulse that survives the chain propagates to Q.

Decomposition:
- Shared package jtag_sync_pkg: localparams MIN_SYNC_STAGES=2 and MIN_FILTER_CYCLES=1, plus the counter-width function.
- Sub-module sync_filter_channel: one bit of chain, filter and edge registers. It is instantiated NR_CHANNELS times in a generate loop.
- The top level adds only the anyEdge register and parameter checks. Elaboration fails if SYNC_STAGES < 2 or FILTER_CYCLES < 1.

Test Plan (NR_CHANNELS=4, SYNC_STAGES=2, FILTER_CYCLES=3, RESET_VALUE=0, 10 ns clock, D driven 1 ns after a clock edge):
1. Reset with D=4'hF, then release and hold D=4'hF -> while reset is high, Q=0 and all pulses are 0. After release, Q=4'hF appears 5 edges after the first sampling edge, risingEdge=4'hF for exactly one cycle, anyEdge=1 in that same cycle, and nothing follows.
2. Glitch: D[0] high for 2 cycles, then low -> Q=0 and no pulses. With the macro undefined, Q[0] goes high for 2 cycles with rising then falling pulses.
3. From steady 4'hF, clear D[2] -> Q=4'hB 5 edges later, fallingEdge=4'h4 for one cycle, risingEdge=0.
4. Step D from 4'b0011 to 4'b1100 -> in the same cycle Q=4'hC, risingEdge=4'hC, fallingEdge=4'h3, anyEdge=1.
5. Assert reset asynchronously (mid-cycle) while channel 1 is pending with cnt=2 -> Q drops to 0 immediately, no pulse is produced, and a fresh 5-cycle latency applies after release.
6. Toggle D[1] every cycle for 20 cycles -> Q[1] stays 0 and no pulses appear. Variant with SYNC_STAGES=4, FILTER_CYCLES=1 and a clean D[3] step -> Q[3] changes 5 edges later.
